// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle RV32I controller (master) and its datapath (slave).
// Carries instruction fields and the zero flag in, and per-state datapath controls out; no flow control.
interface multicycle_control_fsm_if #(
    parameter int STATE_WIDTH   = 4,
    parameter int ALUCTRL_WIDTH = 3
);
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic                     funct7;
    logic                     zero;
    logic                     PCWrite;
    logic                     AdrSrc;
    logic                     Memwrite;
    logic                     IRWrite;
    logic                     RegWrite;
    logic [1:0]               ResultSrc;
    logic [1:0]               ALUSrcA;
    logic [1:0]               ALUSrcB;
    logic [1:0]               ImmSrc;
    logic [ALUCTRL_WIDTH-1:0] ALUControl;
    logic [STATE_WIDTH-1:0]   state;
    logic                     illegal_instr;

    modport master (
        input  opcode, funct3, funct7, zero,
        output PCWrite, AdrSrc, Memwrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state, illegal_instr
    );

    modport slave (
        output opcode, funct3, funct7, zero,
        input  PCWrite, AdrSrc, Memwrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state, illegal_instr
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main controller: Moore decode of the state register, zero-latency outputs, no backpressure.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes / unsupported branch funct3 in a sticky TRAP state.
module multicycle_control_fsm #(
    parameter int STATE_WIDTH   = 4,
    parameter int ALUCTRL_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_fsm_if.master    bus
);
    typedef enum logic [STATE_WIDTH-1:0] {
        S_FETCH    = STATE_WIDTH'(0),
        S_DECODE   = STATE_WIDTH'(1),
        S_MEMADR   = STATE_WIDTH'(2),
        S_MEMREAD  = STATE_WIDTH'(3),
        S_MEMWB    = STATE_WIDTH'(4),
        S_MEMWRITE = STATE_WIDTH'(5),
        S_EXECR    = STATE_WIDTH'(6),
        S_ALUWB    = STATE_WIDTH'(7),
        S_EXECI    = STATE_WIDTH'(8),
        S_JAL      = STATE_WIDTH'(9),
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_BRANCH   = STATE_WIDTH'(10),
        S_TRAP     = STATE_WIDTH'(11)
`else
        S_BRANCH   = STATE_WIDTH'(10)
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = ALUCTRL_WIDTH'(0);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = ALUCTRL_WIDTH'(1);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND = ALUCTRL_WIDTH'(2);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR  = ALUCTRL_WIDTH'(3);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT = ALUCTRL_WIDTH'(5);

    state_t                   r_state;
    state_t                   w_dec_state;
    logic                     w_pcwrite;
    logic                     w_adrsrc;
    logic                     w_memwrite;
    logic                     w_irwrite;
    logic                     w_regwrite;
    logic [1:0]               w_resultsrc;
    logic [1:0]               w_alusrca;
    logic [1:0]               w_alusrcb;
    logic [1:0]               w_immsrc;
    logic [ALUCTRL_WIDTH-1:0] w_aluctrl;
    logic [ALUCTRL_WIDTH-1:0] w_funct_alu;
    logic                     w_branch_taken;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                     w_illegal;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_RTYPE:          r_state <= S_EXECR;
                        OP_ITYPE:          r_state <= S_EXECI;
                        OP_JAL:            r_state <= S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        OP_BRANCH:         r_state <= (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                        default:           r_state <= S_TRAP;
`else
                        OP_BRANCH:         r_state <= S_BRANCH;
                        default:           r_state <= S_FETCH;
`endif
                    endcase
                end
                S_MEMADR:   r_state <= (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  r_state <= S_MEMWB;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_JAL:      r_state <= S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP:     r_state <= S_TRAP;
`endif
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // funct7 only distinguishes sub from add on register-register ops
    always_comb begin
        w_funct_alu = ALU_ADD;
        case (bus.funct3)
            3'b000:  w_funct_alu = (bus.opcode == OP_RTYPE && bus.funct7) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct_alu = ALU_SLT;
            3'b110:  w_funct_alu = ALU_OR;
            3'b111:  w_funct_alu = ALU_AND;
            default: w_funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        w_immsrc = 2'b00;
        case (bus.opcode)
            OP_STORE:  w_immsrc = 2'b01;
            OP_BRANCH: w_immsrc = 2'b10;
            OP_JAL:    w_immsrc = 2'b11;
            default:   w_immsrc = 2'b00;
        endcase
    end

    assign w_branch_taken = (bus.funct3 == 3'b000 &&  bus.zero) ||
                            (bus.funct3 == 3'b001 && !bus.zero);
    // Under reset the datapath sees the FETCH decode; enables are masked below
    assign w_dec_state = reset ? S_FETCH : r_state;

    always_comb begin
        w_pcwrite   = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluctrl   = ALU_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
        w_illegal   = 1'b0;
`endif
        case (w_dec_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_pcwrite   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            S_MEMREAD:  w_adrsrc = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECR: begin
                w_alusrca = 2'b10;
                w_aluctrl = w_funct_alu;
            end
            S_ALUWB:    w_regwrite = 1'b1;
            S_EXECI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluctrl = w_funct_alu;
            end
            S_JAL: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b10;
                w_pcwrite = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca = 2'b10;
                w_aluctrl = ALU_SUB;
                w_pcwrite = w_branch_taken;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     w_illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.PCWrite    = w_pcwrite  & ~reset;
    assign bus.IRWrite    = w_irwrite  & ~reset;
    assign bus.RegWrite   = w_regwrite & ~reset;
    assign bus.Memwrite   = w_memwrite & ~reset;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ImmSrc     = w_immsrc;
    assign bus.ALUControl = w_aluctrl;
    assign bus.state      = r_state;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal_instr = w_illegal;
`else
    assign bus.illegal_instr = 1'b0;
`endif
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller for the multicycle build of the RV32I core. It sits directly upstream of the datapath.
- Inputs: the opcode, funct3 and funct7 fields from the registered instruction, plus the ALU zero flag.
- Outputs: per-state datapath control (PC/IR write enables, mux selects, ALU operation, register-file and data-memory write enables).
- Moore-style FSM. The only Mealy term is the branch-qualified PCWrite.

Parameters:
STATE_WIDTH, 4, width of state register and debug state port
ALUCTRL_WIDTH, 3, width of ALUControl (fixed encoding below; not for override)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
opcode  input  7  instr[6:0]
funct3  input  3  instr[14:12]
funct7  input  1  instr[30]
zero  input  1  ALU zero flag, valid in BRANCH state
PCWrite  output  1  PC register load enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
Memwrite  output  1  data memory write enable
IRWrite  output  1  instruction/OldPC register load enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J (decoded from opcode, combinational)
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
state  output  STATE_WIDTH  current state, debug
illegal_instr  output  1  see Optional Feature; tied 0 when feature is out

Behaviour:
- State register updates on posedge clk. reset=1 at an edge forces state=FETCH. There is no other reset path.
- While reset=1, PCWrite, IRWrite, RegWrite and Memwrite are forced to 0, regardless of state. All other outputs follow the FETCH decode.
- All other outputs are combinational from state (and opcode/funct fields/zero where noted). Zero-latency decode.
- States and encodings; unlisted outputs are 0 or 00.
  - FETCH=0: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1 -> DECODE.
  - DECODE=1: ALUSrcA=01, ALUSrcB=01, add (branch/jal target to ALUOut).
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - other -> FETCH (see Optional Feature)
  - MEMADR=2: ALUSrcA=10, ALUSrcB=01, add. opcode 0000011 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD=3: AdrSrc=1, ResultSrc=00 -> MEMWB.
  - MEMWB=4: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE=5: AdrSrc=1, ResultSrc=00, Memwrite=1 -> FETCH.
  - EXECR=6: ALUSrcA=10, ALUSrcB=00, ALUControl from funct decode -> ALUWB.
  - ALUWB=7: ResultSrc=00, RegWrite=1 -> FETCH.
  - EXECI=8: ALUSrcA=10, ALUSrcB=01, funct decode -> ALUWB.
  - JAL=9: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
  - BRANCH=10: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00 -> FETCH.
    - PCWrite = (funct3==000 & zero) | (funct3==001 & ~zero).
    - Any other funct3 -> PCWrite=0.
- Funct decode (EXECR/EXECI only):
  - funct3 000: sub only if opcode==0110011 and funct7=1; else add. funct7 is ignored for I-type.
  - funct3 010 -> slt; 110 -> or; 111 -> and; all other funct3 -> add.
- ImmSrc decode from opcode:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else -> 00
- Cycle counts per instruction: lw 5, sw 4, R/I-type 4, jal 4, branch 3.
- Unused state codes (11..15 when feature is out) -> next state FETCH, all enables 0.
- Reset mid-instruction: abandon the instruction; next cycle is FETCH with no partial write.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: DECODE with an unrecognised opcode, or BRANCH-class opcode with funct3 not 000/001, -> TRAP=11.
  - TRAP: all enables 0, illegal_instr=1.
  - Stays in TRAP until reset.
- Undefined: an unrecognised opcode returns to FETCH (executes as 2-cycle NOP); branch funct3 other than 000/001 is not-taken; illegal_instr is tied 0; TRAP is not encoded.

Test Plan:
- Reset: hold reset 2 cycles, release -> state=0. During reset, PCWrite=IRWrite=RegWrite=Memwrite=0. First cycle after release: IRWrite=1, PCWrite=1, ALUSrcB=10.
- R-type sub (opcode 0110011, funct3 000, funct7 1) -> states 0,1,6,7. ALUControl=001 in state 6. RegWrite=1 only in state 7. Back to 0 on cycle 5.
- lw (0000011) -> states 0,1,2,3,4. AdrSrc=1 in state 3, ResultSrc=01 with RegWrite=1 in state 4. sw (0100011) -> 0,1,2,5, Memwrite=1 only in state 5, ImmSrc=01.
- beq (1100011, funct3 000): zero=1 -> PCWrite=1 in state 10; zero=0 -> PCWrite=0. bne (funct3 001) gives the inverse. ImmSrc=10. 3 cycles each.
- Illegal opcode 1111111: with CTRL_ILLEGAL_TRAP_EN, state=11 and illegal_instr=1, held 10 cycles until reset. Without the macro, sequence is 0,1,0 with no write enables asserted in state 1.
- Reset asserted in state 3 (lw): next state 0; RegWrite never asserted for the aborted lw.
